barrel_shifter_pipe: RTL and testbench
======================================

# barrel_shifter_pipe

- Parametrised, pipelined barrel shifter with four shift/rotate modes and a valid/ready handshake on both sides.
- Shifts or rotates a WIDTH-bit word by 0..WIDTH-1 positions in log2(WIDTH) registered stages. One result is available per clock.
- Successor to the 4-bit combinational shifter. It sits between a producer and a consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 8, data width; power of two, 4..64
- STAGES, $clog2(WIDTH), derived (localparam): number of pipeline stages and shift-amount width

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  in_data/in_amt/in_mode are valid
- in_ready  output  1  block accepts input this cycle
- in_data  input  WIDTH  operand
- in_amt  input  STAGES  shift amount, 0..WIDTH-1
- in_mode  input  2  00 rotate left, 01 rotate right, 10 logical shift left, 11 arithmetic shift right
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0; qualified by out_valid

## Operation
- Stage k (k = 0..STAGES-1) applies a shift of 2^k positions when amount bit k is 1, otherwise passes the data through. Stages are applied in ascending k.
- Each stage register holds: data, the remaining amount bits, mode, valid.
- Modes:
  - Rotate modes wrap bits around.
  - Logical left fills vacated bits with 0.
  - Arithmetic right fills with the operand MSB. Every stage uses the current MSB, which equals the original sign.
- A transfer occurs on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- stall = out_valid & ~out_ready. in_ready = ~stall, combinational.
- While stalled, all stage registers hold their contents, including bubbles. Bubbles are not collapsed.
- When not stalled, every stage advances. Stage 0 loads the input, with valid = in_valid.
- The amount is always in range because in_amt has exactly STAGES bits. Amount 0 passes the operand unchanged in every mode.
- out_zero is registered alongside the last stage. It is not a combinational compare on the output.

## Timing
- Latency: an input accepted at edge N produces out_valid at edge N+STAGES, assuming no stall.
- Throughput: 1 per cycle when out_ready is held high.
- Reset:
  - All valid bits, data, amount and mode registers clear to 0.
  - out_valid=0, out_data=0, out_zero=0.
  - in_ready=1 one cycle after reset.
- in_ready is 1 during reset, because out_valid=0; the input is ignored while rst=1.
- Reset mid-operation: every in-flight word is discarded. No out_valid occurs for any of them afterwards.
- Simultaneous stall and input: if out_valid & ~out_ready, then in_ready=0. in_data may change freely and is not captured.
- When out_ready rises, the held output transfers and a new input is accepted on the same edge.
- out_data, out_zero and out_valid stay stable while out_valid & ~out_ready.

## Structure
- Package barrel_pkg holds the mode constants: MODE_ROL=2'b00, MODE_ROR=2'b01, MODE_LSL=2'b10, MODE_ASR=2'b11.
- Sub-module barrel_stage (parameters WIDTH, SHIFT) contains:
  - combinational 2^k shift of one word per mode,
  - the stage register with hold on stall.
- The top level instantiates STAGES copies in a generate loop and owns the stall and in_ready logic.

## Test plan
- WIDTH=4, mode 00, in_data=4'b1101, amt 1 then 2:
  - out 4'b1011, then 4'b0111,
  - each appears 2 cycles after acceptance.
- WIDTH=4, in_data=4'b1101 and 4'b0110:
  - mode 01 amt 1 on 1101 -> 4'b1110,
  - mode 11 amt 2 on 1101 -> 4'b1111,
  - mode 10 amt 1 on 0110 -> 4'b1100.
- WIDTH=8, back-to-back stream with out_ready=1:
  - 8'h81 mode 00 amt 1 -> 8'h03,
  - 8'h81 mode 01 amt 1 -> 8'hC0,
  - 8'hB4 mode 11 amt 3 -> 8'hF6,
  - 8'hFF mode 10 amt 7 -> 8'h80,
  - results appear on consecutive cycles after 3-cycle latency;
  - 8'hFF mode 10 amt 0 -> 8'hFF, out_zero=0;
  - 8'h01 mode 10 amt 1... not zero; 8'h80 mode 10 amt 1 -> 8'h00, out_zero=1.
- Backpressure, WIDTH=8: stream 5 words, drop out_ready for 4 cycles mid-stream.
  - in_ready=0 while stalled.
  - out_data held constant.
  - All 5 results delivered in order; none lost or duplicated.
- Reset mid-operation: assert rst for 1 cycle with 3 words in flight.
  - out_valid stays 0 for the following STAGES cycles.
  - Outputs are 0 after reset.
  - The next accepted word produces the correct result.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared constants for the pipelined barrel shifter.
// Mode encodings are used by the stage datapath and by producers.
package barrel_pkg;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Producer/consumer handshake bundle for barrel_shifter_pipe.
// The shifter takes the slave side; the environment drives the master side.
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 8
);

    localparam int STAGES = $clog2(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [STAGES-1:0] in_amt;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );

endinterface

// File: rtl/barrel_stage.sv
// One barrel-shifter stage: conditional shift by SHIFT positions,
// followed by a register that holds its contents while stalled.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    input  logic [AW-1:0]    d_amt,
    input  logic [1:0]       d_mode,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data,
    output logic [AW-1:0]    q_amt,
    output logic [1:0]       q_mode,
    output logic             q_zero
);

    localparam int BIT = $clog2(SHIFT);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] nxt;

    // The current MSB still equals the original sign for ASR.
    always_comb begin
        shifted = d_data;
        unique case (d_mode)
            MODE_ROL: shifted = {d_data[WIDTH-SHIFT-1:0],
                                 d_data[WIDTH-1:WIDTH-SHIFT]};
            MODE_ROR: shifted = {d_data[SHIFT-1:0],
                                 d_data[WIDTH-1:SHIFT]};
            MODE_LSL: shifted = {d_data[WIDTH-SHIFT-1:0],
                                 {SHIFT{1'b0}}};
            MODE_ASR: shifted = {{SHIFT{d_data[WIDTH-1]}},
                                 d_data[WIDTH-1:SHIFT]};
        endcase
    end

    assign nxt = d_amt[BIT] ? shifted : d_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_amt   <= '0;
            q_mode  <= '0;
            q_zero  <= 1'b0;
        end else if (!stall) begin
            q_valid <= d_valid;
            q_data  <= nxt;
            q_amt   <= d_amt;
            q_mode  <= d_mode;
            q_zero  <= (nxt == '0);
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) stages, one result per clock,
// whole pipe freezes (bubbles included) while the consumer stalls.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    barrel_shifter_pipe_if.slave bus
);

    localparam int STAGES = $clog2(WIDTH);

    logic              stall;
    logic              valid_s [STAGES+1];
    logic [WIDTH-1:0]  data_s  [STAGES+1];
    logic [STAGES-1:0] amt_s   [STAGES+1];
    logic [1:0]        mode_s  [STAGES+1];
    logic [STAGES-1:0] zero_s;
    logic              unused_ok;

    assign valid_s[0] = bus.in_valid;
    assign data_s[0]  = bus.in_data;
    assign amt_s[0]   = bus.in_amt;
    assign mode_s[0]  = bus.in_mode;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k),
            .AW    (STAGES)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .stall   (stall),
            .d_valid (valid_s[k]),
            .d_data  (data_s[k]),
            .d_amt   (amt_s[k]),
            .d_mode  (mode_s[k]),
            .q_valid (valid_s[k+1]),
            .q_data  (data_s[k+1]),
            .q_amt   (amt_s[k+1]),
            .q_mode  (mode_s[k+1]),
            .q_zero  (zero_s[k])
        );
    end

    // Only the last stage's zero flag and no trailing amt/mode are consumed.
    assign unused_ok = ^{zero_s[STAGES-2:0], amt_s[STAGES], mode_s[STAGES]};

    assign stall         = valid_s[STAGES] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = valid_s[STAGES];
    assign bus.out_data  = data_s[STAGES];
    assign bus.out_zero  = zero_s[STAGES-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH=8 and WIDTH=4,
// with a step-by-step reference model of the four modes.
module tb_barrel_shifter_pipe;
    import barrel_pkg::*;

    typedef struct {
        logic [63:0] v;
        int          acc;
        int          st;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   st8 = 0;
    int   st4 = 0;
    bit   rnd_done = 1'b0;

    logic [63:0] exp8_cur = '0;
    logic [63:0] exp4_cur = '0;
    ent_t q8[$];
    ent_t q4[$];

    barrel_shifter_pipe_if #(.WIDTH(8)) b8 ();
    barrel_shifter_pipe_if #(.WIDTH(4)) b4 ();

    barrel_shifter_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
    barrel_shifter_pipe #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_model(int w, logic [63:0] d,
                                              int amt, logic [1:0] m);
        logic [63:0] mask;
        logic [63:0] r;
        logic        lo;
        logic        hi;
        mask = (64'd1 << w) - 64'd1;
        r    = d & mask;
        for (int i = 0; i < amt; i++) begin
            hi = r[w-1];
            lo = r[0];
            case (m)
                2'b00:   r = (r << 1) | {63'd0, hi};
                2'b01:   r = (r >> 1) | ({63'd0, lo} << (w - 1));
                2'b10:   r = r << 1;
                default: r = (r >> 1) | ({63'd0, hi} << (w - 1));
            endcase
            r = r & mask;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Output monitor and input capture, WIDTH=8.
    always @(negedge clk) begin
        ent_t e;
        if (b8.out_valid) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected actual=%0h expected=none",
                         b8.out_data);
            end else begin
                e = q8[0];
                chk("w8_data", {56'd0, b8.out_data}, e.v);
                chk("w8_zero", {63'd0, b8.out_zero}, {63'd0, e.v == 64'd0});
                if (b8.out_ready) begin
                    chk("w8_latency", 64'(cyc - e.acc),
                        64'(3 + st8 - e.st));
                    void'(q8.pop_front());
                end else begin
                    chk("w8_in_ready_stall", {63'd0, b8.in_ready}, 64'd0);
                end
            end
            if (!b8.out_ready) st8++;
        end
        if (rst) q8.delete();
        else if (b8.in_valid && b8.in_ready)
            q8.push_back('{exp8_cur, cyc, st8});
    end

    // Output monitor and input capture, WIDTH=4.
    always @(negedge clk) begin
        ent_t e;
        if (b4.out_valid) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w4_unexpected actual=%0h expected=none",
                         b4.out_data);
            end else begin
                e = q4[0];
                chk("w4_data", {60'd0, b4.out_data}, e.v);
                chk("w4_zero", {63'd0, b4.out_zero}, {63'd0, e.v == 64'd0});
                if (b4.out_ready) begin
                    chk("w4_latency", 64'(cyc - e.acc),
                        64'(2 + st4 - e.st));
                    void'(q4.pop_front());
                end else begin
                    chk("w4_in_ready_stall", {63'd0, b4.in_ready}, 64'd0);
                end
            end
            if (!b4.out_ready) st4++;
        end
        if (rst) q4.delete();
        else if (b4.in_valid && b4.in_ready)
            q4.push_back('{exp4_cur, cyc, st4});
    end

    task automatic send8(input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] m, input logic [63:0] exp);
        int n = 0;
        exp8_cur    = exp;
        b8.in_valid = 1'b1;
        b8.in_data  = d;
        b8.in_amt   = a;
        b8.in_mode  = m;
        @(negedge clk);
        while (!b8.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL w8_accept_timeout actual=stuck expected=accept");
        end
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.in_data  = 8'($urandom);
    endtask

    task automatic send4(input logic [3:0] d, input logic [1:0] a,
                         input logic [1:0] m, input logic [63:0] exp);
        int n = 0;
        exp4_cur    = exp;
        b4.in_valid = 1'b1;
        b4.in_data  = d;
        b4.in_amt   = a;
        b4.in_mode  = m;
        @(negedge clk);
        while (!b4.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL w4_accept_timeout actual=stuck expected=accept");
        end
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
        b4.in_data  = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(q8.size() + q4.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d8;
        logic [2:0] a8;
        logic [1:0] m8;
        logic [3:0] d4;
        logic [1:0] a4;
        logic [1:0] m4;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.in_amt = '0;
        b8.in_mode = '0; b8.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_amt = '0;
        b4.in_mode = '0; b4.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, b8.in_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, b8.out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, b8.out_data}, 64'd0);
        chk("rst_out_zero", {63'd0, b8.out_zero}, 64'd0);
        chk("rst_w4_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("rst_w4_ready", {63'd0, b4.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // WIDTH=4 directed vectors, one at a time then a short stream.
        send4(4'b1101, 2'd1, MODE_ROL, 64'b1011);
        drain();
        send4(4'b1101, 2'd2, MODE_ROL, 64'b0111);
        send4(4'b1101, 2'd1, MODE_ROR, 64'b1110);
        send4(4'b1101, 2'd2, MODE_ASR, 64'b1111);
        send4(4'b0110, 2'd1, MODE_LSL, 64'b1100);
        drain();

        // WIDTH=8 back-to-back stream.
        send8(8'h81, 3'd1, MODE_ROL, 64'h03);
        send8(8'h81, 3'd1, MODE_ROR, 64'hC0);
        send8(8'hB4, 3'd3, MODE_ASR, 64'hF6);
        send8(8'hFF, 3'd7, MODE_LSL, 64'h80);
        send8(8'hFF, 3'd0, MODE_LSL, 64'hFF);
        send8(8'h01, 3'd1, MODE_LSL, 64'h02);
        send8(8'h80, 3'd1, MODE_LSL, 64'h00);
        send8(8'h5A, 3'd0, MODE_ASR, 64'h5A);
        drain();

        // Backpressure mid-stream.
        fork
            begin
                send8(8'h11, 3'd1, MODE_ROL, 64'h22);
                send8(8'h96, 3'd2, MODE_ROR, 64'hA5);
                send8(8'h90, 3'd4, MODE_ASR, 64'hF9);
                send8(8'h0F, 3'd4, MODE_LSL, 64'hF0);
                send8(8'h3C, 3'd6, MODE_ROL, 64'h0F);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                b8.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                b8.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three words in flight.
        send8(8'h12, 3'd1, MODE_ROL, 64'h24);
        send8(8'h34, 3'd2, MODE_ROL, 64'hD0);
        send8(8'h56, 3'd3, MODE_ROL, 64'hB2);
        b8.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        b8.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", {56'd0, b8.out_data}, 64'd0);
        chk("mid_rst_zero", {63'd0, b8.out_zero}, 64'd0);
        chk("mid_rst_ready", {63'd0, b8.in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_valid", {63'd0, b8.out_valid}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send8(8'h5A, 3'd4, MODE_ROL, 64'hA5);
        drain();

        // Random traffic on both widths with random backpressure.
        fork
            begin
                fork
                    repeat (200) begin
                        d8 = 8'($urandom);
                        a8 = 3'($urandom);
                        m8 = 2'($urandom);
                        send8(d8, a8, m8, ref_model(8, 64'(d8), int'(a8), m8));
                    end
                    repeat (120) begin
                        d4 = 4'($urandom);
                        a4 = 2'($urandom);
                        m4 = 2'($urandom);
                        send4(d4, a4, m4, ref_model(4, 64'(d4), int'(a4), m4));
                    end
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    b8.out_ready = ($urandom_range(0, 3) != 0);
                    b4.out_ready = ($urandom_range(0, 2) != 0);
                end
                b8.out_ready = 1'b1;
                b4.out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
